// File: rtl/asm_nibble_serial_mac.sv
// Nibble-serial approximate multiplier: walks A one nibble per clock, adding the
// matching precomputed odd multiple of B (shifted) into a 2*WIDTH accumulator.
module asm_nibble_serial_mac #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH+2:0]   I1,
  input  logic [WIDTH+2:0]   I3,
  input  logic [WIDTH+2:0]   I5,
  input  logic [WIDTH+2:0]   I7,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               approx
);

  localparam int NIBBLES      = WIDTH / 4;
  localparam int LOG2_NIBBLES = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [LOG2_NIBBLES-1:0] LAST_IDX = LOG2_NIBBLES'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                    state_q;
  logic [LOG2_NIBBLES-1:0]   idx_q;
  logic [WIDTH-1:0]          a_q;
  logic [WIDTH+2:0]          i1_q, i3_q, i5_q, i7_q;
  logic [2*WIDTH-1:0]        acc_q, acc_d;
  logic                      approx_acc_q, approx_acc_d;
  logic                      in_ready_q, out_valid_q;
  logic [2*WIDTH-1:0]        p_q;
  logic                      approx_q;

  logic [3:0]                nib, nib_eff;
  logic                      nib_apx;
  logic [1:0]                sel_code, shift;
  logic                      nz;
  logic [WIDTH+2:0]          sel;
  logic [LOG2_NIBBLES+2:0]   shamt;
  logic [2*WIDTH-1:0]        pp;

  // a_q is shifted right each RUN cycle, so the current nibble is always the low one.
  always_comb begin
    nib      = a_q[3:0];
    nib_apx  = nib[0] && (nib >= 4'd9);
    nib_eff  = nib_apx ? (nib - 4'd1) : nib;
    sel_code = 2'd0;
    shift    = 2'd0;
    nz       = 1'b1;
    case (nib_eff)
      4'd1:    shift = 2'd0;
      4'd2:    shift = 2'd1;
      4'd4:    shift = 2'd2;
      4'd8:    shift = 2'd3;
      4'd3:    sel_code = 2'd1;
      4'd6:    begin sel_code = 2'd1; shift = 2'd1; end
      4'd12:   begin sel_code = 2'd1; shift = 2'd2; end
      4'd5:    sel_code = 2'd2;
      4'd10:   begin sel_code = 2'd2; shift = 2'd1; end
      4'd7:    sel_code = 2'd3;
      4'd14:   begin sel_code = 2'd3; shift = 2'd1; end
      default: nz = 1'b0;
    endcase
  end

  always_comb begin
    case (sel_code)
      2'd0:    sel = i1_q;
      2'd1:    sel = i3_q;
      2'd2:    sel = i5_q;
      default: sel = i7_q;
    endcase
  end

  // Bits shifted past 2*WIDTH are always zero because the result never exceeds A*B.
  assign shamt        = {1'b0, idx_q, 2'b00} + {{(LOG2_NIBBLES + 1){1'b0}}, shift};
  assign pp           = nz ? ({{(WIDTH - 3){1'b0}}, sel} << shamt) : '0;
  assign acc_d        = acc_q + pp;
  assign approx_acc_d = approx_acc_q | nib_apx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      i1_q         <= '0;
      i3_q         <= '0;
      i5_q         <= '0;
      i7_q         <= '0;
      acc_q        <= '0;
      approx_acc_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      p_q          <= '0;
      approx_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            state_q      <= RUN;
            in_ready_q   <= 1'b0;
            a_q          <= A;
            i1_q         <= I1;
            i3_q         <= I3;
            i5_q         <= I5;
            i7_q         <= I7;
            acc_q        <= '0;
            approx_acc_q <= 1'b0;
            idx_q        <= '0;
          end
        end
        RUN: begin
          a_q          <= {4'b0000, a_q[WIDTH-1:4]};
          acc_q        <= acc_d;
          approx_acc_q <= approx_acc_d;
          idx_q        <= idx_q + LOG2_NIBBLES'(1);
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            p_q         <= acc_d;
            approx_q    <= approx_acc_d;
          end
        end
        DONE: begin
          // in_ready comes back one cycle after the result handshake, never in it.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign P         = p_q;
  assign approx    = approx_q;

endmodule

// File: tb/tb_asm_nibble_serial_mac.sv
// Directed and random checks of asm_nibble_serial_mac against a multiply-based
// golden model of the per-nibble n-1 approximation, using a result queue.
`timescale 1ns/1ps
module tb_asm_nibble_serial_mac;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;
  localparam int PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             inValid, inReady, outValid, outReady, approx;
  logic [WIDTH-1:0] opA;
  logic [WIDTH+2:0] i1, i3, i5, i7;
  logic [PW-1:0]    prod;

  typedef struct packed {
    logic [PW-1:0] p;
    logic          ap;
  } expect_t;

  expect_t expQ[$];
  int total = 0;
  int bad   = 0;

  asm_nibble_serial_mac #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inValid),
    .in_ready (inReady),
    .A        (opA),
    .I1       (i1),
    .I3       (i3),
    .I5       (i5),
    .I7       (i7),
    .out_valid(outValid),
    .out_ready(outReady),
    .P        (prod),
    .approx   (approx)
  );

  always #5 clk = ~clk;

  function automatic expect_t goldenModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    expect_t       r;
    logic [3:0]    n;
    logic [PW-1:0] term;
    r = '0;
    for (int i = 0; i < NIB; i++) begin
      n = a[4*i +: 4];
      if (n inside {4'd9, 4'd11, 4'd13, 4'd15}) begin
        n    = n - 4'd1;
        r.ap = 1'b1;
      end
      term = PW'(b) * PW'(n);
      r.p  = r.p + (term << (4 * i));
    end
    return r;
  endfunction

  task automatic setOperands(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    opA = a;
    i1  = (WIDTH+3)'(b);
    i3  = (WIDTH+3)'(b) * (WIDTH+3)'(3);
    i5  = (WIDTH+3)'(b) * (WIDTH+3)'(5);
    i7  = (WIDTH+3)'(b) * (WIDTH+3)'(7);
  endtask

  task automatic checkValue(input string tag, input logic [PW-1:0] observed, input logic [PW-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for in_ready, offer one operation, then scramble the inputs.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int waited = 0;
    while (!inReady && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkValue("acceptWait", PW'(waited < 20), PW'(1));
    setOperands(a, b);
    inValid = 1'b1;
    expQ.push_back(goldenModel(a, b));
    @(posedge clk); #1;
    inValid = 1'b0;
    setOperands($urandom, $urandom);
  endtask

  // Called right after the accepting edge: checks latency, stall stability and handshake.
  task automatic checkOutput(input int stall, input string tag);
    expect_t exp;
    int      edges    = 0;
    logic    sawReady = 1'b0;
    while (!outValid && edges < 4 * NIB) begin
      if (inReady) sawReady = 1'b1;
      inValid = 1'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    inValid = 1'b0;
    checkValue({tag, "_latency"}, PW'(edges), PW'(NIB));
    checkValue({tag, "_readyInRun"}, PW'(sawReady), PW'(0));
    if (expQ.size() > 0) exp = expQ.pop_front();
    else exp = '0;
    for (int s = 0; s < stall; s++) begin
      setOperands($urandom, $urandom);
      @(posedge clk); #1;
      checkValue({tag, "_stallValid"}, PW'(outValid), PW'(1));
      checkValue({tag, "_stallP"}, prod, exp.p);
    end
    outReady = 1'b1;
    checkValue({tag, "_P"}, prod, exp.p);
    checkValue({tag, "_approx"}, PW'(approx), PW'(exp.ap));
    @(posedge clk); #1;
    outReady = 1'b0;
    checkValue({tag, "_validDrop"}, PW'(outValid), PW'(0));
    checkValue({tag, "_readyBack"}, PW'(inReady), PW'(1));
    checkValue({tag, "_pHeld"}, prod, exp.p);
  endtask

  initial begin
    rst_n    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    setOperands($urandom, $urandom);
    repeat (3) begin
      @(negedge clk);
      inValid  = 1'($urandom);
      outReady = 1'($urandom);
      setOperands($urandom, $urandom);
    end
    @(negedge clk);
    checkValue("rstInReady", PW'(inReady), PW'(0));
    checkValue("rstOutValid", PW'(outValid), PW'(0));
    checkValue("rstP", prod, PW'(0));
    checkValue("rstApprox", PW'(approx), PW'(0));
    inValid  = 1'b0;
    outReady = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkValue("releaseReadyLow", PW'(inReady), PW'(0));
    @(posedge clk); #1;
    checkValue("releaseReadyHigh", PW'(inReady), PW'(1));

    applyStimulus(32'h23, 32'd5);
    checkOutput(0, "exact");
    checkValue("exactConst", prod, PW'(175));
    checkValue("exactApproxConst", PW'(approx), PW'(0));

    applyStimulus(32'h9, 32'd10);
    checkOutput(0, "apx9");
    checkValue("apx9Const", prod, PW'(80));
    checkValue("apx9ApproxConst", PW'(approx), PW'(1));

    applyStimulus(32'hFFFF_FFFF, 32'd1);
    checkOutput(1, "apxF");
    checkValue("apxFConst", prod, 64'h0000_0000_EEEE_EEEE);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput(5, "backpressure");
    applyStimulus(32'h0000_0042, 32'd2);
    checkOutput(0, "afterBackpressure");

    applyStimulus(32'h1234_5678, 32'hABCD_EF01);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(expQ.pop_back());
    checkValue("midRunOutValid", PW'(outValid), PW'(0));
    checkValue("midRunInReady", PW'(inReady), PW'(0));
    checkValue("midRunP", prod, PW'(0));
    checkValue("midRunApprox", PW'(approx), PW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h10, 32'd3);
    checkOutput(0, "afterReset");
    checkValue("afterResetConst", prod, PW'(48));

    for (int k = 0; k < 1000; k++) begin
      applyStimulus($urandom, $urandom);
      checkOutput(int'($urandom_range(0, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
